// File: rtl/renode_pkg.sv
// Shared types for the Renode interrupt bridge blocks.
// Events carry a line index and the new level of that line.
package renode_pkg;

  localparam int unsigned MaxInterrupts = 256;

  typedef struct packed {
    logic [7:0] addr;
    logic       level;
  } irq_event_t;

endpackage

// File: rtl/renode_sync_fifo.sv
// Synchronous FIFO with registered head, reusable by Renode bridges.
// Wrap-bit pointers distinguish full from empty.
module renode_sync_fifo #(
  parameter type T     = logic,
  parameter int  Depth = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  T                             data_i,
  input  logic                         pop_i,
  output T                             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int AW = $clog2(Depth);

  T             mem_q [Depth];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  // A pop frees the slot being written, so a full FIFO can push and pop together.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/renode_irq_event_queue.sv
// Turns interrupt line changes into queued {index, level} events.
// Lowest pending line wins; transient toggles set a sticky flag.
module renode_irq_event_queue
  import renode_pkg::*;
#(
  parameter  int InterruptsCount = 1,
  parameter  int FifoDepth       = 4,
  localparam int AddrWidth = (InterruptsCount < 2) ? 1 : $clog2(InterruptsCount),
  localparam int CntW      = $clog2(FifoDepth + 1)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [InterruptsCount-1:0] interrupts,
  output logic                       event_valid,
  input  logic                       event_ready,
  output logic [AddrWidth-1:0]       event_addr,
  output logic                       event_level,
  output logic [CntW-1:0]            event_count,
  output logic                       coalesced,
  input  logic                       coalesced_clr
);

  logic [InterruptsCount-1:0] reported_q, reported_d;
  logic [InterruptsCount-1:0] pend_q;
  logic [InterruptsCount-1:0] enq_q, enq_d;
  logic [InterruptsCount-1:0] pending;
  logic [AddrWidth-1:0]       sel;
  logic                       coalesced_q, coalesced_d;
  logic                       push, pop, full, empty;
  logic                       coal_evt;
  irq_event_t                 in_ev, head;

  assign pending = interrupts ^ reported_q;
  assign pop     = ~empty & event_ready;
  assign push    = (|pending) & (~full | pop);

  always_comb begin
    sel = '0;
    for (int i = InterruptsCount - 1; i >= 0; i--) begin
      if (pending[i]) sel = AddrWidth'(i);
    end
  end

  always_comb begin
    reported_d = reported_q;
    enq_d      = '0;
    in_ev.addr  = 8'(sel);
    in_ev.level = interrupts[sel];
    if (push) begin
      reported_d[sel] = interrupts[sel];
      enq_d[sel]      = 1'b1;
    end
  end

  // A line that was waiting and is no longer pending without being queued
  assign coal_evt = |(pend_q & ~enq_q & ~pending);

  always_comb begin
    coalesced_d = coalesced_q;
    if (coalesced_clr) coalesced_d = 1'b0;
    if (coal_evt)      coalesced_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reported_q  <= '0;
      pend_q      <= '0;
      enq_q       <= '0;
      coalesced_q <= 1'b0;
    end else begin
      reported_q  <= reported_d;
      pend_q      <= pending;
      enq_q       <= enq_d;
      coalesced_q <= coalesced_d;
    end
  end

  renode_sync_fifo #(
    .T     (irq_event_t),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push_i  (push),
    .data_i  (in_ev),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (event_count)
  );

  assign event_valid = ~empty;
  assign event_addr  = AddrWidth'(head.addr);
  assign event_level = head.level;
  assign coalesced   = coalesced_q;

endmodule

// File: tb/tb_renode_irq_event_queue.sv
// Scoreboard bench: two instances, depth 4 and depth 2.
// Expected events are queued at drive time and popped on handshake.
module tb_renode_irq_event_queue;
  import renode_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, rst_b_n;
  logic [3:0] irq_a, irq_b;
  logic       rdy_a, rdy_b, clr_a, clr_b;
  logic       a_valid, b_valid, a_level, b_level, a_coal, b_coal;
  logic [1:0] a_addr, b_addr;
  logic [2:0] a_cnt;
  logic [1:0] b_cnt;

  int vectors = 0;
  int miscompares = 0;
  irq_event_t qa[$];
  irq_event_t qb[$];
  irq_event_t ea, eb;

  renode_irq_event_queue #(
    .InterruptsCount (4),
    .FifoDepth       (4)
  ) u_dut_a (
    .clk           (clk),
    .resetn        (rst_a_n),
    .interrupts    (irq_a),
    .event_valid   (a_valid),
    .event_ready   (rdy_a),
    .event_addr    (a_addr),
    .event_level   (a_level),
    .event_count   (a_cnt),
    .coalesced     (a_coal),
    .coalesced_clr (clr_a)
  );

  renode_irq_event_queue #(
    .InterruptsCount (4),
    .FifoDepth       (2)
  ) u_dut_b (
    .clk           (clk),
    .resetn        (rst_b_n),
    .interrupts    (irq_b),
    .event_valid   (b_valid),
    .event_ready   (rdy_b),
    .event_addr    (b_addr),
    .event_level   (b_level),
    .event_count   (b_cnt),
    .coalesced     (b_coal),
    .coalesced_clr (clr_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic irq_event_t ev(input int a, input logic l);
    irq_event_t e;
    e.addr  = 8'(a);
    e.level = l;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_a_n === 1'b1 && a_valid && rdy_a) begin
      if (qa.size() == 0) chk("a_unexp", 32'(qa.size()), 1);
      else begin
        ea = qa.pop_front();
        chk("a_addr", 32'(a_addr), 32'(ea.addr));
        chk("a_lvl", 32'(a_level), 32'(ea.level));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b_n === 1'b1 && b_valid && rdy_b) begin
      if (qb.size() == 0) chk("b_unexp", 32'(qb.size()), 1);
      else begin
        eb = qb.pop_front();
        chk("b_addr", 32'(b_addr), 32'(eb.addr));
        chk("b_lvl", 32'(b_level), 32'(eb.level));
      end
    end
  end

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    irq_a = '0; irq_b = '0;
    rdy_a = 1'b0; rdy_b = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    tick(2);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_addr", 32'(a_addr), 0);
    chk("rst_level", 32'(a_level), 0);
    chk("rst_cnt", 32'(a_cnt), 0);
    chk("rst_coal", 32'(a_coal), 0);
    chk("rst_b_valid", 32'(b_valid), 0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    tick(1);

    // two simultaneous rises, consumer always ready
    rdy_a = 1'b1;
    irq_a = 4'b0101;
    qa.push_back(ev(0, 1'b1));
    qa.push_back(ev(2, 1'b1));
    tick(1);
    chk("t1_valid", 32'(a_valid), 1);
    chk("t1_addr0", 32'(a_addr), 0);
    chk("t1_cnt0", 32'(a_cnt), 1);
    tick(1);
    chk("t1_addr2", 32'(a_addr), 2);
    chk("t1_cnt1", 32'(a_cnt), 1);
    tick(1);
    chk("t1_empty", 32'(a_valid), 0);
    tick(2);
    chk("t1_drain", 32'(qa.size()), 0);

    // fill all four with consumer stalled
    irq_a = 4'b0000;
    qa.push_back(ev(0, 1'b0));
    qa.push_back(ev(2, 1'b0));
    tick(4);
    chk("t2_pre", 32'(qa.size()), 0);
    rdy_a = 1'b0;
    irq_a = 4'b1111;
    for (int i = 0; i < 4; i++) qa.push_back(ev(i, 1'b1));
    tick(6);
    chk("t2_cnt", 32'(a_cnt), 4);
    chk("t2_valid", 32'(a_valid), 1);
    chk("t2_head", 32'(a_addr), 0);
    rdy_a = 1'b1;
    tick(6);
    chk("t2_cnt_end", 32'(a_cnt), 0);
    chk("t2_drain", 32'(qa.size()), 0);

    // reset while popping discards the queue
    rdy_a = 1'b0;
    irq_a = 4'b0001;
    qa.push_back(ev(1, 1'b0));
    qa.push_back(ev(2, 1'b0));
    qa.push_back(ev(3, 1'b0));
    tick(4);
    chk("t5_cnt3", 32'(a_cnt), 3);
    rdy_a = 1'b1;
    irq_a = 4'b0010;
    tick(1);
    rst_a_n = 1'b0;
    qa.delete();
    #1;
    chk("t5_rst_valid", 32'(a_valid), 0);
    chk("t5_rst_addr", 32'(a_addr), 0);
    chk("t5_rst_level", 32'(a_level), 0);
    chk("t5_rst_cnt", 32'(a_cnt), 0);
    tick(1);
    chk("t5_rst_hold", 32'(a_valid), 0);
    #2;
    rst_a_n = 1'b1;
    qa.push_back(ev(1, 1'b1));
    tick(1);
    chk("t5_valid", 32'(a_valid), 1);
    chk("t5_addr", 32'(a_addr), 1);
    tick(4);
    chk("t5_cnt", 32'(a_cnt), 0);
    chk("t5_drain", 32'(qa.size()), 0);

    // line 0 toggling every cycle
    for (int i = 0; i < 8; i++) begin
      irq_a[0] = ~irq_a[0];
      qa.push_back(ev(0, irq_a[0]));
      tick(1);
      chk("t6_valid", 32'(a_valid), 1);
    end
    tick(3);
    chk("t6_drain", 32'(qa.size()), 0);
    chk("t6_cnt", 32'(a_cnt), 0);
    chk("t6_coal", 32'(a_coal), 0);

    // depth 2: a blip on line 3 while full is coalesced
    rdy_b = 1'b0;
    irq_b = 4'b0011;
    qb.push_back(ev(0, 1'b1));
    qb.push_back(ev(1, 1'b1));
    tick(3);
    chk("t3_full", 32'(b_cnt), 2);
    irq_b = 4'b1011;
    tick(2);
    chk("t3_wait", 32'(b_cnt), 2);
    chk("t3_nocoal", 32'(b_coal), 0);
    irq_b = 4'b0011;
    tick(1);
    chk("t3_coal", 32'(b_coal), 1);
    tick(2);
    chk("t3_sticky", 32'(b_coal), 1);
    clr_b = 1'b1;
    tick(1);
    clr_b = 1'b0;
    chk("t3_clr", 32'(b_coal), 0);

    // full with pop and push on the same edge
    rdy_b = 1'b1;
    irq_b = 4'b0001;
    qb.push_back(ev(1, 1'b0));
    tick(1);
    chk("t4_cnt", 32'(b_cnt), 2);
    chk("t4_head", 32'(b_addr), 1);
    chk("t4_hlvl", 32'(b_level), 1);
    tick(4);
    chk("t4_cnt_end", 32'(b_cnt), 0);
    chk("t4_drain", 32'(qb.size()), 0);
    chk("t4_coal", 32'(b_coal), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
